// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit accumulator processor.
// Opcode encodings and default datapath widths.
package proc_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_IMM_W  = 8;

    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SUBI = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BR   = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

endpackage

// File: rtl/reg_bank.sv
// General register storage: sync clear, one write port,
// two asynchronous read ports with no write bypass.
module reg_bank
    import proc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Clear everything on reset; otherwise write port A's address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[address_a] <= write_data;
        end
    end

    assign data_a = regs[address_a];
    assign data_b = regs[address_b];

endmodule

// File: rtl/reg_alu_datapath.sv
// Register bank plus combinational ALU slice.
// Operands are port A, port B and the zero-extended immediate.
module reg_alu_datapath
    import proc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    input  logic [3:0]        opcode,
    input  logic [IMM_W-1:0]  immediate,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero
);

    logic [DATA_W-1:0] imm_ext;

    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, immediate};

    reg_bank #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .address_a   (address_a),
        .address_b   (address_b),
        .write_enable(write_enable),
        .write_data  (write_data),
        .data_a      (data_a),
        .data_b      (data_b)
    );

    // Opcode-selected ALU; jumps, branches and unused codes yield 0.
    always_comb begin
        alu_result = '0;
        case (opcode)
            OP_LOAD: alu_result = imm_ext;
            OP_ADD:  alu_result = data_a + data_b;
            OP_ADDI: alu_result = data_a + imm_ext;
            OP_SUB:  alu_result = data_a - data_b;
            OP_SUBI: alu_result = data_a - imm_ext;
            OP_MOV:  alu_result = data_b;
            OP_OUT:  alu_result = data_a;
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == '0);

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Self-checking bench for reg_alu_datapath.
// Directed plan cases followed by randomized traffic vs a model.
module tb_reg_alu_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  address_a;
    logic [2:0]  address_b;
    logic        write_enable;
    logic [15:0] write_data;
    logic [3:0]  opcode;
    logic [7:0]  immediate;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [15:0] alu_result;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;
    int model [8];

    reg_alu_datapath dut (
        .clk         (clk),
        .rst         (rst),
        .address_a   (address_a),
        .address_b   (address_b),
        .write_enable(write_enable),
        .write_data  (write_data),
        .opcode      (opcode),
        .immediate   (immediate),
        .data_a      (data_a),
        .data_b      (data_b),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int ref_alu(input int op, input int a,
                                   input int b, input int i);
        int r;
        case (op)
            1:       r = i;
            2:       r = a + b;
            10:      r = a + i;
            3:       r = a - b;
            11:      r = a - i;
            14:      r = b;
            15:      r = a;
            default: r = 0;
        endcase
        return r & 16'hFFFF;
    endfunction

    // One clock edge, then apply the same rule to the model.
    task automatic tick();
        bit r, w;
        int a, d;
        r = rst; w = write_enable; a = address_a; d = write_data;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 8; i++) model[i] = 0;
        end else if (w) begin
            model[a] = d;
        end
    endtask

    task automatic wr(input int a, input int d);
        address_a    = 3'(a);
        write_data   = 16'(d);
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic chk_alu(input string tag, input int res, input bit z);
        #1;
        chk({tag, "_res"}, 32'(alu_result), 32'(res));
        chk({tag, "_z"}, 32'(alu_zero), 32'(z));
    endtask

    initial begin
        int exp;
        rst = 1'b1; write_enable = 1'b0; write_data = '0;
        address_a = '0; address_b = '0; opcode = '0; immediate = '0;
        for (int i = 0; i < 8; i++) model[i] = 32'hDEAD;
        tick();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            address_a = 3'(i); address_b = 3'(i);
            #1;
            chk("rst_a", 32'(data_a), 0);
            chk("rst_b", 32'(data_b), 0);
        end
        opcode = 4'b0010;
        chk_alu("rst_add", 0, 1'b1);

        wr(3, 16'h1234);
        address_b = 3'd3;
        #1 chk("wr_r3", 32'(data_b), 32'h1234);

        // Read of the address being written returns the old value.
        address_a = 3'd3; write_data = 16'h5555; write_enable = 1'b1;
        #1 chk("no_bypass", 32'(data_a), 32'h1234);
        tick();
        write_enable = 1'b0;
        chk("after_wr", 32'(data_a), 32'h5555);

        wr(1, 16'h0005);
        address_a = 3'd1; opcode = 4'b1010; immediate = 8'hFB;
        chk_alu("addi", 16'h0100, 1'b0);
        opcode = 4'b0001;
        chk_alu("load", 16'h00FB, 1'b0);

        wr(1, 7); wr(2, 7);
        address_a = 3'd1; address_b = 3'd2; opcode = 4'b0011;
        chk_alu("sub", 0, 1'b1);
        opcode = 4'b1011; immediate = 8'd8;
        chk_alu("subi", 16'hFFFF, 1'b0);

        wr(4, 16'hFFFF); wr(5, 1);
        address_a = 3'd4; address_b = 3'd5; opcode = 4'b0010;
        chk_alu("wrap", 0, 1'b1);

        wr(6, 16'hBEEF);
        address_b = 3'd6; opcode = 4'b1110;
        chk_alu("mov", 16'hBEEF, 1'b0);
        address_a = 3'd6; opcode = 4'b1111;
        chk_alu("out", 16'hBEEF, 1'b0);
        opcode = 4'b1000;
        chk_alu("jmp", 0, 1'b1);

        rst = 1'b1; write_enable = 1'b1;
        address_a = 3'd2; write_data = 16'hAAAA;
        tick();
        rst = 1'b0; write_enable = 1'b0;
        address_b = 3'd2;
        #1 chk("rst_prio", 32'(data_b), 0);
        address_b = 3'd6;
        #1 chk("rst_clr", 32'(data_b), 0);

        for (int n = 0; n < 400; n++) begin
            address_a    = 3'($urandom_range(0, 7));
            address_b    = 3'($urandom_range(0, 7));
            opcode       = 4'($urandom);
            immediate    = 8'($urandom);
            write_data   = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                                       : 16'($urandom);
            write_enable = 1'($urandom);
            rst          = ($urandom_range(0, 39) == 0);
            #1;
            chk("rnd_a", 32'(data_a), 32'(model[address_a]));
            chk("rnd_b", 32'(data_b), 32'(model[address_b]));
            exp = ref_alu(int'(opcode), model[address_a],
                          model[address_b], int'(immediate));
            chk("rnd_res", 32'(alu_result), 32'(exp));
            chk("rnd_z", 32'(alu_zero), 32'(exp == 0));
            tick();
        end
        rst = 1'b0; write_enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_alu_datapath.md
# reg_alu_datapath

Register-file-plus-ALU datapath slice for the 16-bit accumulator-style processor. It holds eight 16-bit general registers with two combinational read ports and one synchronous write port. It also evaluates the ALU operation selected by the 4-bit instruction opcode on the two read operands or an 8-bit immediate. The processor's decode/sequencing logic drives addresses, opcode, immediate and write controls, and consumes `alu_result`, `alu_zero`, `data_a` and `data_b`.

## Interface
Parameters:
- `DATA_W`, default 16: register and ALU data width.
- `ADDR_W`, default 3: register address width; the bank holds 2**ADDR_W = 8 registers.
- `IMM_W`, default 8: immediate width.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `address_a` input ADDR_W: read port A address; also the write destination.
- `address_b` input ADDR_W: read port B address.
- `write_enable` input 1: when high, `write_data` is written to `address_a` at the next edge.
- `write_data` input DATA_W: data to write.
- `opcode` input 4: ALU operation select.
- `immediate` input IMM_W: immediate operand, zero-extended to DATA_W.
- `data_a` output DATA_W: register[address_a], combinational.
- `data_b` output DATA_W: register[address_b], combinational.
- `alu_result` output DATA_W: combinational ALU result.
- `alu_zero` output 1: high when `alu_result` == 0, combinational.

## Operation
Register bank:
- At a rising edge with `rst` high, all 8 registers clear to 0. Reset has priority over the write path.
- Otherwise, with `write_enable` high, register[address_a] takes `write_data`.
- Reads are asynchronous; there is no write-to-read bypass.

ALU, combinational on `data_a` (A), `data_b` (B) and zext(immediate) (I). All arithmetic is modulo 2**DATA_W; there is no carry or overflow output.
- 4'b0001 load: I.
- 4'b0010 add: A+B.
- 4'b1010 addi: A+I.
- 4'b0011 sub: A−B.
- 4'b1011 subi: A−I.
- 4'b1110 mov: B.
- 4'b1111 out: A.
- Any other opcode (jmp 1000, br 1100, reserved): 0.

Zero flag:
- `alu_zero` = (`alu_result` == 0) for every opcode.
- The processor samples it only for sub/subi; the block itself stores no flag.

## Timing
- Read latency is 0 cycles: `data_a`, `data_b`, `alu_result` and `alu_zero` settle within the same cycle as address, opcode or immediate changes.
- Write latency is 1 edge. Data written at edge N is visible on the read ports immediately after edge N.
- Simultaneous read and write of the same address: the read returns the old value until the edge.
- Write to any address (0–7) is legal; there is no hard-wired zero register.
- `rst` asserted mid-operation: the pending write is discarded and all registers are 0 after that edge.
- Outputs during and after reset follow the cleared registers: `data_a` = `data_b` = 0. `alu_result` follows the opcode, e.g. add → 0, `alu_zero` = 1.
- Wrap-around: 16'hFFFF + 1 = 0 with `alu_zero` = 1. 0 − 1 = 16'hFFFF.

## Structure
- Shared package `proc_pkg` holds:
  - opcode localparams: `OP_LOAD`, `OP_ADD`, `OP_ADDI`, `OP_SUB`, `OP_SUBI`, `OP_JMP`, `OP_BR`, `OP_MOV`, `OP_OUT`;
  - DATA_W, ADDR_W and IMM_W defaults.
- One natural sub-module, `reg_bank`: the 8×16 storage with synchronous reset and write plus two asynchronous read ports.
- The ALU is a combinational case statement in the top module.

## Test plan
- Reset and write: assert `rst` for 1 cycle, then write 16'h1234 to r3. Before the write, `data_a`/`data_b` read 0 at every address; after it, `address_b`=3 gives `data_b`=16'h1234.
- Immediate ops: r1 = 16'h0005; `opcode`=1010 (addi), `immediate`=8'hFB with `address_a`=1 → `alu_result`=16'h0100, `alu_zero`=0. `opcode`=0001 (load) → 16'h00FB.
- Subtract and zero flag: r1=7, r2=7, `opcode`=0011 → `alu_result`=0, `alu_zero`=1. `opcode`=1011 with `immediate`=8 → 16'hFFFF, `alu_zero`=0.
- Wrap-around: r4=16'hFFFF, r5=1, `opcode`=0010 → `alu_result`=0, `alu_zero`=1.
- Mov/out/default: r6=16'hBEEF. `opcode`=1110 with `address_b`=6 → 16'hBEEF. `opcode`=1111 with `address_a`=6 → 16'hBEEF. `opcode`=1000 → 0.
- Reset priority: `rst`=1 and `write_enable`=1 writing 16'hAAAA to r2 in the same cycle → r2 reads 0 after the edge.
